// File: rtl/rv32im_dmem_bridge_pkg.sv
// Shared LSU opcode encodings, data widths and bridge FSM states.
// Opcode bit 3 marks a store; bits [1:0] give the access size.
package rv32im_dmem_bridge_pkg;

    localparam int API_DATA_WIDTH   = 32;
    localparam int LSU_OPCODE_WIDTH = 4;

    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LB  = 4'b0000;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LH  = 4'b0001;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LW  = 4'b0010;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LBU = 4'b0100;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_LHU = 4'b0101;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SB  = 4'b1000;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SH  = 4'b1001;
    localparam logic [LSU_OPCODE_WIDTH-1:0] LSU_OPCODE_SW  = 4'b1010;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_REQ  = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_e;

endpackage

// File: rtl/rv32im_dmem_lane.sv
// Byte-enable, store-lane replication and alignment check for one request.
// Purely combinational; the bridge latches its outputs when it accepts.
module rv32im_dmem_lane
    import rv32im_dmem_bridge_pkg::*;
(
    input  logic [LSU_OPCODE_WIDTH-1:0] opcode,
    input  logic [1:0]                  addr_lo,
    input  logic [API_DATA_WIDTH-1:0]   data,
    output logic [3:0]                  be,
    output logic [API_DATA_WIDTH-1:0]   wdata,
    output logic                        we,
    output logic                        misalign
);

    logic [API_DATA_WIDTH-1:0] repl;

    always_comb begin
        be       = 4'b0000;
        repl     = '0;
        we       = 1'b0;
        misalign = 1'b0;
        case (opcode)
            LSU_OPCODE_LB, LSU_OPCODE_LBU, LSU_OPCODE_SB: begin
                be   = 4'b0001 << addr_lo;
                repl = {4{data[7:0]}};
            end
            LSU_OPCODE_LH, LSU_OPCODE_LHU, LSU_OPCODE_SH: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                repl     = {2{data[15:0]}};
                misalign = addr_lo[0];
            end
            LSU_OPCODE_LW, LSU_OPCODE_SW: begin
                be       = 4'b1111;
                repl     = data;
                misalign = |addr_lo;
            end
            default: ;
        endcase
        we    = (opcode == LSU_OPCODE_SB) || (opcode == LSU_OPCODE_SH) ||
                (opcode == LSU_OPCODE_SW);
        wdata = we ? repl : '0;
    end

endmodule

// File: rtl/rv32im_dmem_bridge.sv
// Sequential data-memory port below the LSU: one outstanding req/gnt/rvalid
// access, with misalign rejection, error passthrough and a wait timeout.
module rv32im_dmem_bridge
    import rv32im_dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 7
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        lsu_req_i,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic [API_DATA_WIDTH-1:0]   addr_mem_i,
    input  logic [API_DATA_WIDTH-1:0]   val_memwr_i,
    output logic [API_DATA_WIDTH-1:0]   val_memrd_o,
    output logic                        lsu_busy_o,
    output logic                        lsu_done_o,
    output logic                        lsu_misalign_o,
    output logic                        lsu_buserr_o,
    output logic                        dmem_req_o,
    output logic                        dmem_we_o,
    output logic [3:0]                  dmem_be_o,
    output logic [API_DATA_WIDTH-1:0]   dmem_addr_o,
    output logic [API_DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic                        dmem_gnt_i,
    input  logic                        dmem_rvalid_i,
    input  logic [API_DATA_WIDTH-1:0]   dmem_rdata_i,
    input  logic                        dmem_err_i
);

    dmem_state_e               state_q, state_d;
    logic [TMO_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                be_q;
    logic [API_DATA_WIDTH-1:0] wdata_q, addr_q, rdata_q;
    logic                      we_q;
    logic                      done_q, done_d;
    logic                      buserr_q, buserr_d;
    logic                      mis_q, mis_d;
    logic                      accept, latch_rd, tmo_hit, finish;

    logic [3:0]                lane_be;
    logic [API_DATA_WIDTH-1:0] lane_wdata;
    logic                      lane_we, lane_mis;

    rv32im_dmem_lane u_lane (
        .opcode   (lsu_opcode_i),
        .addr_lo  (addr_mem_i[1:0]),
        .data     (val_memwr_i),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .we       (lane_we),
        .misalign (lane_mis)
    );

    // Counter value k means k+1 cycles spent waiting in the current state.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        buserr_d = 1'b0;
        mis_d    = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        latch_rd = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (lsu_req_i) begin
                    if (lane_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = DMEM_REQ;
                    end
                end
            end
            DMEM_REQ: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (dmem_gnt_i && dmem_rvalid_i) begin
                    finish = 1'b1;
                end else if (dmem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = DMEM_RESP;
                end else if (tmo_hit) begin
                    buserr_d = 1'b1;
                    state_d  = DMEM_IDLE;
                end
            end
            DMEM_RESP: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (dmem_rvalid_i) begin
                    finish = 1'b1;
                end else if (tmo_hit) begin
                    buserr_d = 1'b1;
                    state_d  = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
        if (finish) begin
            state_d  = DMEM_IDLE;
            done_d   = !dmem_err_i;
            buserr_d = dmem_err_i;
            latch_rd = !we_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            buserr_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            buserr_q <= buserr_d;
            mis_q    <= mis_d;
            if (accept) begin
                be_q    <= lane_be;
                wdata_q <= lane_wdata;
                we_q    <= lane_we;
                addr_q  <= {addr_mem_i[API_DATA_WIDTH-1:2], 2'b00};
            end
            if (latch_rd) begin
                rdata_q <= dmem_rdata_i;
            end
        end
    end

    assign dmem_req_o     = (state_q == DMEM_REQ);
    assign dmem_we_o      = dmem_req_o & we_q;
    assign dmem_be_o      = dmem_req_o ? be_q : 4'b0000;
    assign dmem_addr_o    = dmem_req_o ? addr_q : '0;
    assign dmem_wdata_o   = dmem_req_o ? wdata_q : '0;
    assign lsu_busy_o     = (state_q != DMEM_IDLE);
    assign lsu_done_o     = done_q;
    assign lsu_buserr_o   = buserr_q;
    assign lsu_misalign_o = mis_q;
    assign val_memrd_o    = rdata_q;

endmodule

// File: tb/tb_rv32im_dmem_bridge.sv
// Scoreboard bench for rv32im_dmem_bridge: directed accesses with a
// hand-driven bus, expected status pulses queued at issue time.
module tb_rv32im_dmem_bridge;
    import rv32im_dmem_bridge_pkg::*;

    localparam int TMO = 6;

    typedef struct {
        int          kind;
        logic [31:0] rd;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0;
    logic [3:0]  lsu_opcode = '0;
    logic [31:0] addr_mem = '0;
    logic [31:0] val_memwr = '0;
    logic [31:0] val_memrd;
    logic        lsu_busy, lsu_done, lsu_misalign, lsu_buserr;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_err = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    sb_t         sb[$];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    rv32im_dmem_bridge #(.TIMEOUT_CYCLES(TMO), .TMO_W(7)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .lsu_req_i      (lsu_req),
        .lsu_opcode_i   (lsu_opcode),
        .addr_mem_i     (addr_mem),
        .val_memwr_i    (val_memwr),
        .val_memrd_o    (val_memrd),
        .lsu_busy_o     (lsu_busy),
        .lsu_done_o     (lsu_done),
        .lsu_misalign_o (lsu_misalign),
        .lsu_buserr_o   (lsu_buserr),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_be_o      (dmem_be),
        .dmem_addr_o    (dmem_addr),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_gnt_i     (dmem_gnt),
        .dmem_rvalid_i  (dmem_rvalid),
        .dmem_rdata_i   (dmem_rdata),
        .dmem_err_i     (dmem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 done, 1 buserr, 2 misalign
    always @(negedge clk) begin
        if (rst_n && (lsu_done || lsu_buserr || lsu_misalign)) begin
            sb_t e;
            int  k;
            k = lsu_done ? 0 : (lsu_buserr ? 1 : 2);
            chk("pulse_excl", 32'(lsu_done) + 32'(lsu_buserr) +
                32'(lsu_misalign), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("val_memrd", val_memrd, e.rd);
            end
        end
    end

    // rw = cycles from gnt to rvalid; 0 means rvalid alongside gnt
    task automatic access(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int gw,
                          input int rw, input logic err,
                          input logic [31:0] rdata, input logic [3:0] xbe,
                          input logic [31:0] xwdata);
        sb_t         e;
        logic [31:0] xaddr;
        xaddr  = addr & 32'hFFFF_FFFC;
        e.kind = err ? 1 : 0;
        e.rd   = op[3] ? last_rd : rdata;
        last_rd = e.rd;
        sb.push_back(e);
        lsu_req = 1'b1; lsu_opcode = op; addr_mem = addr; val_memwr = data;
        step();
        lsu_req = 1'b0; lsu_opcode = '0; addr_mem = '0; val_memwr = '0;
        for (int i = 0; i <= gw; i++) begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("busy", 32'(lsu_busy), 32'd1);
            chk("addr", dmem_addr, xaddr);
            chk("be", 32'(dmem_be), 32'(xbe));
            chk("wdata", dmem_wdata, xwdata);
            chk("we", 32'(dmem_we), 32'(op[3]));
            if (i == gw) begin
                dmem_gnt = 1'b1;
                if (rw == 0) begin
                    dmem_rvalid = 1'b1; dmem_err = err; dmem_rdata = rdata;
                end
            end
            step();
        end
        dmem_gnt = 1'b0;
        if (rw > 0) begin
            dmem_rvalid = 1'b0;
            for (int i = 1; i < rw; i++) begin
                chk("resp_wait", {30'd0, lsu_busy, dmem_req}, 32'd2);
                step();
            end
            chk("resp_busy", 32'(lsu_busy), 32'd1);
            dmem_rvalid = 1'b1; dmem_err = err; dmem_rdata = rdata;
            step();
        end
        dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
        chk("finish_pulse", 32'(lsu_done | lsu_buserr), 32'd1);
        chk("finish_idle", 32'(lsu_busy), 32'd0);
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] addr);
        sb_t e;
        e.kind = 2;
        e.rd   = last_rd;
        sb.push_back(e);
        lsu_req = 1'b1; lsu_opcode = op; addr_mem = addr; val_memwr = 32'h5A5A;
        step();
        lsu_req = 1'b0; lsu_opcode = '0; addr_mem = '0;
        chk("mis_pulse", 32'(lsu_misalign), 32'd1);
        chk("mis_noreq", 32'(dmem_req), 32'd0);
        chk("mis_nobusy", 32'(lsu_busy), 32'd0);
        step();
        chk("mis_noreq2", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(lsu_busy), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rd", val_memrd, 32'd0);
        rst_n = 1'b1;
        step();

        access(LSU_OPCODE_LW, 32'h100, 32'h0, 0, 1, 1'b0, 32'h000C_F5BD,
               4'b1111, 32'h0);
        access(LSU_OPCODE_SB, 32'h103, 32'hA5, 0, 1, 1'b0, 32'h0,
               4'b1000, 32'hA5A5_A5A5);
        access(LSU_OPCODE_SH, 32'h102, 32'h1234, 0, 2, 1'b0, 32'h0,
               4'b1100, 32'h1234_1234);
        misaligned(LSU_OPCODE_LH, 32'h101);
        // gnt arrives on the last cycle before the timeout would fire
        access(LSU_OPCODE_LW, 32'h204, 32'h0, 5, 1, 1'b0, 32'hDEAD_BEEF,
               4'b1111, 32'h0);
        access(LSU_OPCODE_LBU, 32'h301, 32'h0, 0, 0, 1'b0, 32'h1122_3344,
               4'b0010, 32'h0);
        access(LSU_OPCODE_LB, 32'h302, 32'h0, 2, 3, 1'b0, 32'h5566_7788,
               4'b0100, 32'h0);
        access(LSU_OPCODE_SW, 32'h400, 32'hCAFE_F00D, 1, 1, 1'b1, 32'h0,
               4'b1111, 32'hCAFE_F00D);
        misaligned(LSU_OPCODE_SW, 32'h402);

        begin
            sb_t e;
            e.kind = 1;
            e.rd   = last_rd;
            sb.push_back(e);
            lsu_req = 1'b1; lsu_opcode = LSU_OPCODE_LW; addr_mem = 32'h500;
            step();
            lsu_req = 1'b0;
            for (int i = 0; i < TMO; i++) begin
                chk("tmo_req", 32'(dmem_req), 32'd1);
                step();
            end
            chk("tmo_pulse", 32'(lsu_buserr), 32'd1);
            chk("tmo_drop", 32'(dmem_req), 32'd0);
            dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
            step();
            dmem_rvalid = 1'b0; dmem_rdata = '0;
            chk("late_idle", 32'(lsu_busy), 32'd0);
            chk("late_rd", val_memrd, last_rd);
        end

        lsu_req = 1'b1; lsu_opcode = LSU_OPCODE_LW; addr_mem = 32'h700;
        step();
        lsu_req = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("resp_before_rst", 32'(lsu_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(lsu_busy), 32'd0);
        chk("arst_req", 32'(dmem_req), 32'd0);
        chk("arst_done", 32'(lsu_done), 32'd0);
        chk("arst_rd", val_memrd, 32'd0);
        last_rd = '0;
        step();
        rst_n = 1'b1;
        step();
        access(LSU_OPCODE_LW, 32'h600, 32'h0, 0, 1, 1'b0, 32'h0BAD_F00D,
               4'b1111, 32'h0);

        step();
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
